// File: rtl/branch_predictor_unit_pkg.sv
// rtl/branch_predictor_unit_pkg.sv - strategy encodings and 2-bit counter constants for the branch predictor
package branch_predictor_unit_pkg;

    typedef enum logic [1:0] {
        STRAT_NOT_TAKEN = 2'b00,
        STRAT_TAKEN     = 2'b01,
        STRAT_1BIT      = 2'b10,
        STRAT_2BIT      = 2'b11
    } strategy_e;

    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_ALLOC = 2'b10;
    localparam logic [1:0] CTR_RESET = 2'b01;

endpackage

// File: rtl/branch_predictor_unit_sat_counter2.sv
// rtl/branch_predictor_unit_sat_counter2.sv - 2-bit saturating up/down counter next-state logic
module bpu_sat_counter2
    import branch_predictor_unit_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i && (ctr_i != CTR_ST)) begin
            ctr_o = ctr_i + 2'd1;
        end else if (dec_i && (ctr_i != CTR_SNT)) begin
            ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor_unit.sv
// rtl/branch_predictor_unit.sv - direct-mapped BTB with 1-bit/2-bit direction tables and selectable strategy
// Optional BPU_PERF_COUNTERS_EN adds branch and mispredict counters.
module branch_predictor_unit
    import branch_predictor_unit_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int PC_WIDTH   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          Strategy,
    input  logic [PC_WIDTH-1:0] if_pc,
    output logic                pred_hit,
    output logic                pred_taken,
    output logic [PC_WIDTH-1:0] pred_target,
    input  logic                upd_valid,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic [PC_WIDTH-1:0] upd_target,
`ifdef BPU_PERF_COUNTERS_EN
    output logic [31:0]         branch_count,
    output logic [31:0]         mispredict_count,
`endif
    input  logic                upd_mispredict
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = PC_WIDTH - INDEX_BITS - 2;

    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];
    logic                hist1_q  [ENTRIES];
    logic [1:0]          ctr2_q   [ENTRIES];

    logic [INDEX_BITS-1:0] q_idx, u_idx;
    logic [TAG_W-1:0]      q_tag, u_tag;
    logic                  u_hit;
    logic                  dir;
    logic [1:0]            ctr_d;

    assign q_idx = if_pc[INDEX_BITS+1:2];
    assign q_tag = if_pc[PC_WIDTH-1:INDEX_BITS+2];
    assign u_idx = upd_pc[INDEX_BITS+1:2];
    assign u_tag = upd_pc[PC_WIDTH-1:INDEX_BITS+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Prediction reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        dir = 1'b0;
        case (strategy_e'(Strategy))
            STRAT_NOT_TAKEN: dir = 1'b0;
            STRAT_TAKEN:     dir = 1'b1;
            STRAT_1BIT:      dir = hist1_q[q_idx];
            STRAT_2BIT:      dir = ctr2_q[q_idx][1];
            default:         dir = 1'b0;
        endcase
    end

    assign pred_hit    = valid_q[q_idx] && (tag_q[q_idx] == q_tag);
    assign pred_taken  = pred_hit && dir;
    assign pred_target = pred_taken ? target_q[q_idx] : '0;

    bpu_sat_counter2 u_ctr (
        .ctr_i (ctr2_q[u_idx]),
        .inc_i (upd_taken),
        .dec_i (!upd_taken),
        .ctr_o (ctr_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                hist1_q[i]  <= 1'b0;
                ctr2_q[i]   <= CTR_RESET;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                hist1_q[u_idx] <= upd_taken;
                ctr2_q[u_idx]  <= ctr_d;
                if (upd_taken) begin
                    target_q[u_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= upd_target;
                hist1_q[u_idx]  <= 1'b1;
                ctr2_q[u_idx]   <= CTR_ALLOC;
            end
        end
    end

`ifdef BPU_PERF_COUNTERS_EN
    logic [31:0] branch_count_q, mispredict_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (upd_valid) begin
            branch_count_q <= branch_count_q + 32'd1;
            if (upd_mispredict) begin
                mispredict_count_q <= mispredict_count_q + 32'd1;
            end
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

    logic unused_bits;
    assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};
`else
    logic unused_bits;
    assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor_unit.sv
// tb/tb_branch_predictor_unit.sv - directed scoreboard bench for branch_predictor_unit
module tb_branch_predictor_unit;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  Strategy;
    logic [31:0] if_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid, upd_taken, upd_mispredict;
    logic [31:0] upd_pc, upd_target;
`ifdef BPU_PERF_COUNTERS_EN
    logic [31:0] branch_count, mispredict_count;
    int unsigned exp_branch, exp_misp;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    branch_predictor_unit #(.INDEX_BITS(4), .PC_WIDTH(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .Strategy         (Strategy),
        .if_pc            (if_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
`ifdef BPU_PERF_COUNTERS_EN
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count),
`endif
        .upd_mispredict   (upd_mispredict)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt, input logic mp);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = tgt;
        upd_mispredict = mp;
    endtask

    // One clock edge; the bench's own counter model follows what the edge should do.
    task automatic tick();
        @(posedge clk);
`ifdef BPU_PERF_COUNTERS_EN
        if (reset) begin
            exp_branch = 0;
            exp_misp   = 0;
        end else if (upd_valid) begin
            exp_branch++;
            if (upd_mispredict) exp_misp++;
        end
`endif
        #1;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic query(input string tag, input logic [31:0] pc, input logic eh, input logic et, input logic [31:0] etgt);
        exp_t e;
        if_pc = pc;
        sb_q.push_back('{hit: eh, taken: et, tgt: etgt});
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            cmp({tag, ".hit"},    {31'd0, pred_hit},   {31'd0, e.hit});
            cmp({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, e.taken});
            cmp({tag, ".target"}, pred_target,         e.tgt);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        set_upd(pc, taken, tgt, 1'b0);
        tick();
    endtask

    initial begin
        reset = 1'b1; Strategy = 2'b00; if_pc = 32'd16;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
`ifdef BPU_PERF_COUNTERS_EN
        exp_branch = 0; exp_misp = 0;
`endif
        tick();
        set_upd(32'd16, 1'b1, 32'd28, 1'b1);
        Strategy = 2'b01;
        query("in_reset", 32'd16, 1'b0, 1'b0, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        for (int s = 0; s < 4; s++) begin
            Strategy = s[1:0];
            query($sformatf("reset_s%0d", s), 32'd16, 1'b0, 1'b0, 32'd0);
        end

        Strategy = 2'b11;
        upd(32'd16, 1'b1, 32'd28);
        query("ctr_alloc", 32'd16, 1'b1, 1'b1, 32'd28);
        upd(32'd16, 1'b0, 32'd0);
        query("ctr_01", 32'd16, 1'b1, 1'b0, 32'd0);
        upd(32'd16, 1'b0, 32'd0);
        query("ctr_00", 32'd16, 1'b1, 1'b0, 32'd0);

        Strategy = 2'b10;
        upd(32'd16, 1'b0, 32'd0);
        query("hist_0", 32'd16, 1'b1, 1'b0, 32'd0);
        upd(32'd16, 1'b1, 32'd28);
        query("hist_1", 32'd16, 1'b1, 1'b1, 32'd28);

        Strategy = 2'b00;
        query("static_nt", 32'd16, 1'b1, 1'b0, 32'd0);
        Strategy = 2'b01;
        query("static_t", 32'd16, 1'b1, 1'b1, 32'd28);

        // ctr2 is 01 here; three taken saturate at 11, so one not-taken still predicts taken.
        Strategy = 2'b11;
        upd(32'd16, 1'b1, 32'd28);
        upd(32'd16, 1'b1, 32'd28);
        upd(32'd16, 1'b1, 32'd28);
        upd(32'd16, 1'b0, 32'd0);
        query("ctr_sat_hi", 32'd16, 1'b1, 1'b1, 32'd28);
        upd(32'd16, 1'b0, 32'd0);
        query("ctr_sat_dn", 32'd16, 1'b1, 1'b0, 32'd0);

        Strategy = 2'b01;
        upd(32'd80, 1'b1, 32'd100);
        query("alias_16", 32'd16, 1'b0, 1'b0, 32'd0);
        query("alias_80", 32'd80, 1'b1, 1'b1, 32'd100);
        upd(32'd48, 1'b0, 32'd0);
        query("miss_nt_48", 32'd48, 1'b0, 1'b0, 32'd0);
        query("miss_nt_80", 32'd80, 1'b1, 1'b1, 32'd100);

        set_upd(32'd48, 1'b1, 32'd60, 1'b0);
        query("same_cyc", 32'd48, 1'b0, 1'b0, 32'd0);
        tick();
        query("next_cyc", 32'd48, 1'b1, 1'b1, 32'd60);

`ifdef BPU_PERF_COUNTERS_EN
        cmp("branch_cnt_run", branch_count, exp_branch);
        cmp("misp_cnt_run", mispredict_count, exp_misp);
`endif

        reset = 1'b1;
        set_upd(32'd16, 1'b1, 32'd28, 1'b1);
        tick();
        reset = 1'b0;
        query("rst_upd_16", 32'd16, 1'b0, 1'b0, 32'd0);
        query("rst_upd_48", 32'd48, 1'b0, 1'b0, 32'd0);
`ifdef BPU_PERF_COUNTERS_EN
        cmp("branch_cnt_rst", branch_count, 32'd0);
        cmp("misp_cnt_rst", mispredict_count, 32'd0);
        for (int i = 0; i < 5; i++) begin
            set_upd(32'd16 + 32'(i * 4), i[0], 32'd200, (i == 1) || (i == 3));
            tick();
        end
        upd_mispredict = 1'b1;
        tick();
        cmp("branch_cnt_5", branch_count, 32'd5);
        cmp("misp_cnt_2", mispredict_count, 32'd2);
        cmp("branch_cnt_model", branch_count, exp_branch);
`endif

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
